// File: rtl/seg7_multi_counter.sv
// Multi-digit BCD up/down counter with prescaled stepping, pause, load and a scanned 7-seg driver.
// Latency: count/tick/wrap update on the step edge; an/seg show the previous cycle's state (1 cycle).
// Backpressure: none; load has priority over a step, en=0 freezes count and prescaler, scan never stops.
//
// Ports:
//   clk        posedge clock for all state
//   rst        synchronous reset, active-low
//   en         1 = count, 0 = pause
//   up_dn      count direction, 1 = up
//   load       1-cycle strobe, loads load_val (nibbles clamped to 9)
//   load_val   BCD load value, nibble i = digit i
//   count_bcd  current count, BCD, nibble 0 = least significant digit
//   tick       1-cycle pulse on every count step
//   wrap       1-cycle pulse on a step that wraps all-9 <-> all-0
//   an         one-hot active-high digit select
//   seg        {dp,g,f,e,d,c,b,a}, active-high
module seg7_multi_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1,
    parameter int SCAN_DIV   = 1,
    parameter bit LZ_BLANK   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    up_dn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_val,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    tick,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = (TICK_DIV > 1)   ? $clog2(TICK_DIV)   : 1;
    localparam int SW = (SCAN_DIV > 1)   ? $clog2(SCAN_DIV)   : 1;
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]         presc;
    logic [SW-1:0]         scan_cnt;
    logic [DW-1:0]         digit_idx;

    logic [CW-1:0]         count_next;
    logic                  wrap_next;
    logic [CW-1:0]         load_clamped;
    logic [NUM_DIGITS-1:0] blank;
    logic [NUM_DIGITS-1:0] an_next;
    logic [3:0]            cur_dig;
    logic                  cur_blank;
    logic [7:0]            seg_next;

    logic                  carry;
    logic                  higher_zero;
    logic [3:0]            dig;
    logic [3:0]            nd;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // BCD +/-1 ripple: the carry (or borrow) walks up while digits roll over.
    // A carry still set past the top digit means the whole count rolled over.
    always_comb begin
        count_next = count_bcd;
        carry      = 1'b1;
        dig        = 4'd0;
        nd         = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig = count_bcd[4*i +: 4];
            nd  = dig;
            if (carry) begin
                if (up_dn) begin
                    if (dig >= 4'd9) begin
                        nd = 4'd0;
                    end else begin
                        nd    = dig + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        nd = 4'd9;
                    end else begin
                        nd    = dig - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            count_next[4*i +: 4] = nd;
        end
        wrap_next = carry;
    end

    // Out-of-range load nibbles saturate at 9 so the count stays valid BCD.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
        end
    end

    // Leading-zero mask: walk down from the MSD while every digit seen so far is zero.
    always_comb begin
        blank       = '0;
        higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            higher_zero = higher_zero && (count_bcd[4*i +: 4] == 4'd0);
            blank[i]    = LZ_BLANK && (i != 0) && higher_zero;
        end
    end

    // Select the scanned digit and build the next an/seg values.
    always_comb begin
        an_next   = '0;
        cur_dig   = 4'd0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == DW'(i)) begin
                an_next[i] = 1'b1;
                cur_dig    = count_bcd[4*i +: 4];
                cur_blank  = blank[i];
            end
        end
        seg_next[6:0] = cur_blank ? 7'h00 : seg_decode(cur_dig);
        seg_next[7]   = (digit_idx == '0) && !en;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_bcd <= '0;
            presc     <= '0;
            scan_cnt  <= '0;
            digit_idx <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            an        <= NUM_DIGITS'(1);
            seg       <= 8'h00;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;

            if (load) begin
                count_bcd <= load_clamped;
                presc     <= '0;
            end else if (en) begin
                if (presc == PRESC_LAST) begin
                    presc     <= '0;
                    count_bcd <= count_next;
                    tick      <= 1'b1;
                    wrap      <= wrap_next;
                end else begin
                    presc <= presc + PW'(1);
                end
            end

            if (scan_cnt == SCAN_LAST) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + DW'(1);
            end else begin
                scan_cnt <= scan_cnt + SW'(1);
            end

            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule
